// File: rtl/fwd_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// fwd_hazard_ctrl
//
// Forwarding and load-use hazard controller for a 5-stage DLX integer pipeline.
// Keeps a small tag (valid, reg_write, mem_read, dest) for the instructions
// sitting in EX and MEM, produces registered 3:1 operand-mux selects for the
// instruction in EX, and stalls PC / IF/ID while injecting ID/EX bubbles on a
// load-use hazard. A data-memory freeze (mem_stall) holds the whole pipeline.
//
// Ports:
//   clk, rst_n         pipeline clock (rising edge), async active-low reset
//   id_valid           ID holds a real instruction
//   id_rs, id_rt       ID source registers A / B
//   id_use_rs/_rt      ID instruction actually reads rs / rt
//   id_dest            ID destination register
//   id_reg_write       ID instruction writes id_dest
//   id_mem_read        ID instruction is a load
//   mem_stall          data-memory freeze; everything holds
//   fwd_a_sel/_b_sel   operand mux selects for EX (00 RF, 10 EX/MEM, 01 MEM/WB)
//   pc_write           PC update enable
//   ifid_write         IF/ID update enable
//   idex_bubble        load a NOP into ID/EX on this edge
// -----------------------------------------------------------------------------
module fwd_hazard_ctrl #(
  parameter int reg_addr_size = 5,
  parameter int load_latency  = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     id_valid,
  input  logic [reg_addr_size-1:0] id_rs,
  input  logic [reg_addr_size-1:0] id_rt,
  input  logic                     id_use_rs,
  input  logic                     id_use_rt,
  input  logic [reg_addr_size-1:0] id_dest,
  input  logic                     id_reg_write,
  input  logic                     id_mem_read,
  input  logic                     mem_stall,
  output logic [1:0]               fwd_a_sel,
  output logic [1:0]               fwd_b_sel,
  output logic                     pc_write,
  output logic                     ifid_write,
  output logic                     idex_bubble
);

  localparam logic [1:0] SEL_RF    = 2'b00;
  localparam logic [1:0] SEL_EXMEM = 2'b10;
  localparam logic [1:0] SEL_MEMWB = 2'b01;

  // Remaining bubbles after the first one, loaded when a hazard is seen.
  localparam logic [1:0] STALL_INIT = 2'(load_latency - 1);

  typedef enum logic {RUN, STALL} state_t;

  state_t                   state_reg;
  logic [1:0]               cnt_reg;

  // Tags of the instructions currently in EX and MEM. The instruction in WB
  // needs no tag: the register file writes before it reads, so a WB producer
  // is already visible to ID and the MEM tag simply retires on the next edge.
  logic                     ex_valid_reg, ex_reg_write_reg, ex_mem_read_reg;
  logic [reg_addr_size-1:0] ex_dest_reg;
  logic                     mem_valid_reg, mem_reg_write_reg;
  logic [reg_addr_size-1:0] mem_dest_reg;

  logic [1:0]               fwd_a_sel_reg, fwd_b_sel_reg;
  logic [1:0]               fwd_a_sel_next, fwd_b_sel_next;

  logic                     rs_hit_ex, rt_hit_ex, rs_hit_mem, rt_hit_mem;
  logic                     load_use;

  // Source/producer matches for the instruction currently in ID. Register 0
  // is hard-wired zero and never forwards.
  always_comb begin
    rs_hit_ex  = id_use_rs && (id_rs != '0) && ex_valid_reg &&
                 ex_reg_write_reg && (ex_dest_reg == id_rs);
    rt_hit_ex  = id_use_rt && (id_rt != '0) && ex_valid_reg &&
                 ex_reg_write_reg && (ex_dest_reg == id_rt);
    rs_hit_mem = id_use_rs && (id_rs != '0) && mem_valid_reg &&
                 mem_reg_write_reg && (mem_dest_reg == id_rs);
    rt_hit_mem = id_use_rt && (id_rt != '0) && mem_valid_reg &&
                 mem_reg_write_reg && (mem_dest_reg == id_rt);
  end

  // A load in EX cannot feed an ALU op entering EX next cycle.
  assign load_use = id_valid && ex_mem_read_reg && (rs_hit_ex || rt_hit_ex);

  // Selects for the instruction that will be in EX after this edge: today's
  // EX producer will then sit in EX/MEM, today's MEM producer in MEM/WB.
  // Youngest producer wins when both match.
  always_comb begin
    fwd_a_sel_next = SEL_RF;
    fwd_b_sel_next = SEL_RF;
    if (id_valid && !idex_bubble) begin
      if (rs_hit_ex)       fwd_a_sel_next = SEL_EXMEM;
      else if (rs_hit_mem) fwd_a_sel_next = SEL_MEMWB;
      if (rt_hit_ex)       fwd_b_sel_next = SEL_EXMEM;
      else if (rt_hit_mem) fwd_b_sel_next = SEL_MEMWB;
    end
  end

  // Pipeline enables. The freeze dominates: nothing moves, so no bubble
  // may be injected either.
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_bubble = 1'b0;
    if (mem_stall) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b0;
    end else if ((state_reg == STALL) || load_use) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg         <= RUN;
      cnt_reg           <= 2'd0;
      ex_valid_reg      <= 1'b0;
      ex_reg_write_reg  <= 1'b0;
      ex_mem_read_reg   <= 1'b0;
      ex_dest_reg       <= '0;
      mem_valid_reg     <= 1'b0;
      mem_reg_write_reg <= 1'b0;
      mem_dest_reg      <= '0;
      fwd_a_sel_reg     <= SEL_RF;
      fwd_b_sel_reg     <= SEL_RF;
    end else if (!mem_stall) begin
      mem_valid_reg     <= ex_valid_reg;
      mem_reg_write_reg <= ex_reg_write_reg;
      mem_dest_reg      <= ex_dest_reg;

      if (idex_bubble || !id_valid) begin
        ex_valid_reg     <= 1'b0;
        ex_reg_write_reg <= 1'b0;
        ex_mem_read_reg  <= 1'b0;
        ex_dest_reg      <= '0;
      end else begin
        ex_valid_reg     <= 1'b1;
        ex_reg_write_reg <= id_reg_write;
        ex_mem_read_reg  <= id_mem_read;
        ex_dest_reg      <= id_dest;
      end

      fwd_a_sel_reg <= fwd_a_sel_next;
      fwd_b_sel_reg <= fwd_b_sel_next;

      case (state_reg)
        RUN: begin
          if (load_use) begin
            cnt_reg <= STALL_INIT;
            if (load_latency > 1) state_reg <= STALL;
          end
        end
        STALL: begin
          cnt_reg <= cnt_reg - 2'd1;
          if (cnt_reg == 2'd1) state_reg <= RUN;
        end
        default: state_reg <= RUN;
      endcase
    end
  end

  assign fwd_a_sel = fwd_a_sel_reg;
  assign fwd_b_sel = fwd_b_sel_reg;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fwd_hazard_ctrl
//
// Directed bench for fwd_hazard_ctrl. Two instances share the ID-side inputs:
// u1 with load_latency=1 and u3 with load_latency=3. Inputs change 1 time
// unit after the rising edge; outputs are checked before the next edge.
// -----------------------------------------------------------------------------
module tb_fwd_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid, id_use_rs, id_use_rt, id_reg_write, id_mem_read;
  logic [4:0] id_rs, id_rt, id_dest;
  logic       mem_stall;

  logic [1:0] a1, b1, a3, b3;
  logic       pc1, ifid1, bub1, pc3, ifid3, bub3;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  fwd_hazard_ctrl #(.reg_addr_size(5), .load_latency(1)) u1 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dest(id_dest),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .mem_stall(mem_stall),
    .fwd_a_sel(a1), .fwd_b_sel(b1), .pc_write(pc1), .ifid_write(ifid1),
    .idex_bubble(bub1)
  );

  fwd_hazard_ctrl #(.reg_addr_size(5), .load_latency(3)) u3 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dest(id_dest),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .mem_stall(mem_stall),
    .fwd_a_sel(a3), .fwd_b_sel(b3), .pc_write(pc3), .ifid_write(ifid3),
    .idex_bubble(bub3)
  );

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    $display("t=%0t check %s observed=%b expected=%b", $time, tag, obs, exp);
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt, input logic [4:0] d,
                        input logic rw, input logic mr);
    id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
    id_dest = d; id_reg_write = rw; id_mem_read = mr;
  endtask

  task automatic nop();
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; mem_stall = 1'b0; nop();
    #2;
    chk("rst_a", a1, 2'b00);       chk("rst_b", b1, 2'b00);
    chk("rst_pc", {1'b0, pc1}, 2'b01);
    chk("rst_ifid", {1'b0, ifid1}, 2'b01);
    chk("rst_bub", {1'b0, bub1}, 2'b00);
    tick(); rst_n = 1'b1;

    // ADD r3,r1,r2 ; SUB r5,r3,r4
    set_id(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0); tick();
    set_id(1, 5'd3, 5'd4, 1, 1, 5'd5, 1, 0); tick();
    chk("exfwd_a", a1, 2'b10);     chk("exfwd_b", b1, 2'b00);

    // One-cycle freeze with SUB in EX: selects hold, enables drop
    nop(); mem_stall = 1'b1; #1;
    chk("frz_pc", {1'b0, pc1}, 2'b00);
    chk("frz_ifid", {1'b0, ifid1}, 2'b00);
    chk("frz_bub", {1'b0, bub1}, 2'b00);
    tick();
    chk("frz_a_hold", a1, 2'b10);
    mem_stall = 1'b0; tick();
    chk("frz_release_a", a1, 2'b00);

    // ADD r3 ; NOP ; OR r6,r2,r3
    set_id(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0); tick();
    nop(); tick();
    set_id(1, 5'd2, 5'd3, 1, 1, 5'd6, 1, 0); tick();
    chk("memfwd_a", a1, 2'b00);    chk("memfwd_b", b1, 2'b01);

    // ADD r3 ; ADD r3 ; AND r7,r3,r3
    set_id(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0); tick();
    set_id(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0); tick();
    set_id(1, 5'd3, 5'd3, 1, 1, 5'd7, 1, 0); tick();
    chk("prio_a", a1, 2'b10);      chk("prio_b", b1, 2'b10);

    // Reset mid-run, no clock edge
    rst_n = 1'b0; #1;
    chk("rstrun_a", a1, 2'b00);    chk("rstrun_b", b1, 2'b00);
    chk("rstrun_pc", {1'b0, pc1}, 2'b01);
    chk("rstrun_bub", {1'b0, bub1}, 2'b00);
    rst_n = 1'b1; nop(); tick();

    // ADDI r0 ; consumer of r0
    set_id(1, 5'd1, 5'd0, 1, 0, 5'd0, 1, 0); tick();
    set_id(1, 5'd0, 5'd0, 1, 1, 5'd10, 1, 0); tick();
    chk("r0_a", a1, 2'b00);        chk("r0_b", b1, 2'b00);

    // ADD r4 ; consumer with rs=r4 but id_use_rs=0
    set_id(1, 5'd1, 5'd2, 1, 1, 5'd4, 1, 0); tick();
    set_id(1, 5'd4, 5'd1, 0, 1, 5'd11, 1, 0); tick();
    chk("unused_a", a1, 2'b00);

    // LW r8 ; ADD r9,r8,r1
    nop(); tick(); nop(); tick();
    set_id(1, 5'd1, 5'd0, 1, 0, 5'd8, 1, 1); tick();
    set_id(1, 5'd8, 5'd1, 1, 1, 5'd9, 1, 0); #1;
    chk("lu1_pc", {1'b0, pc1}, 2'b00);
    chk("lu1_ifid", {1'b0, ifid1}, 2'b00);
    chk("lu1_bub", {1'b0, bub1}, 2'b01);
    chk("lu3_bub0", {1'b0, bub3}, 2'b01);
    tick();
    chk("lu1_pc_after", {1'b0, pc1}, 2'b01);
    chk("lu1_bub_after", {1'b0, bub1}, 2'b00);
    chk("lu3_pc1", {1'b0, pc3}, 2'b00);
    chk("lu3_bub1", {1'b0, bub3}, 2'b01);
    tick();
    chk("lu1_fwd_a", a1, 2'b01);   chk("lu1_fwd_b", b1, 2'b00);
    chk("lu3_bub2", {1'b0, bub3}, 2'b01);
    tick();
    chk("lu3_pc_done", {1'b0, pc3}, 2'b01);
    chk("lu3_bub_done", {1'b0, bub3}, 2'b00);
    tick();
    chk("lu3_fwd_a", a3, 2'b00);

    // Freeze for 4 cycles in the middle of a 3-cycle load-use stall
    nop(); tick(); nop(); tick();
    set_id(1, 5'd1, 5'd0, 1, 0, 5'd8, 1, 1); tick();
    set_id(1, 5'd8, 5'd1, 1, 1, 5'd9, 1, 0); #1;
    chk("ms_bub0", {1'b0, bub3}, 2'b01);
    tick();
    chk("ms_bub1", {1'b0, bub3}, 2'b01);
    mem_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("ms_hold%0d_pc", i), {1'b0, pc3}, 2'b00);
      chk($sformatf("ms_hold%0d_ifid", i), {1'b0, ifid3}, 2'b00);
      chk($sformatf("ms_hold%0d_bub", i), {1'b0, bub3}, 2'b00);
      tick();
    end
    mem_stall = 1'b0; #1;
    chk("ms_resume_bub1", {1'b0, bub3}, 2'b01);
    chk("ms_resume_pc", {1'b0, pc3}, 2'b00);
    tick();
    chk("ms_bub2", {1'b0, bub3}, 2'b01);
    tick();
    chk("ms_done_pc", {1'b0, pc3}, 2'b01);
    chk("ms_done_bub", {1'b0, bub3}, 2'b00);

    // Reset asserted while STALL is active
    nop(); tick(); nop(); tick();
    set_id(1, 5'd1, 5'd0, 1, 0, 5'd8, 1, 1); tick();
    set_id(1, 5'd8, 5'd1, 1, 1, 5'd9, 1, 0); tick();
    chk("rs_stall_bub", {1'b0, bub3}, 2'b01);
    rst_n = 1'b0; #1;
    chk("rs_pc", {1'b0, pc3}, 2'b01);
    chk("rs_ifid", {1'b0, ifid3}, 2'b01);
    chk("rs_bub", {1'b0, bub3}, 2'b00);
    chk("rs_a", a3, 2'b00);
    nop(); tick(); rst_n = 1'b1; tick();
    chk("rs_after_pc", {1'b0, pc3}, 2'b01);
    chk("rs_after_bub", {1'b0, bub3}, 2'b00);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
